hdl_result_checker: RTL and testbench

Streaming result checker placed directly downstream of `func_hdl_top`. It consumes the kernel's `ovalid`/data stream and discards the first `IN_OUT_LAT` valid beats, which are latency-padding outputs. The remaining `SIZE` beats are compared against a golden-result memory, within an absolute integer tolerance, and written to a result buffer port. It reports pass/fail, the error count, the first failing index and a work-instance count, so self-checking runs and on-board checks need no host-side comparison.

---
 rtl/hdl_result_checker.sv | 192 +++++++++++++++++++
 tb/tb_hdl_result_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hdl_result_checker.sv
// Streaming checker: skips IN_OUT_LAT leading beats, compares SIZE beats to golden RAM within TOL.
// Always ready, no backpressure; res_we one cycle after a beat, done two cycles after the last beat.
module hdl_result_checker #(
  parameter int          DATAW      = 32,
  parameter int          SIZE       = 1024,
  parameter int          IN_OUT_LAT = 8,
  parameter int          ADDRW      = 16,
  parameter int unsigned TOL        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ovalid_in,
  input  logic [DATAW-1:0] odata_in,
  output logic [ADDRW-1:0] gold_addr,
  input  logic [DATAW-1:0] gold_data,
  output logic             res_we,
  output logic [ADDRW-1:0] res_addr,
  output logic [DATAW-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ADDRW-1:0] err_count,
  output logic [ADDRW-1:0] first_err_idx,
  output logic [DATAW-1:0] first_err_exp,
  output logic [DATAW-1:0] first_err_got,
  output logic [15:0]      wi_count,
  output logic             stray
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SKIP  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SKW    = (IN_OUT_LAT > 1) ? $clog2(IN_OUT_LAT + 1) : 1;
  localparam int LAT_M1 = (IN_OUT_LAT > 0) ? IN_OUT_LAT - 1 : 0;
  localparam logic [SKW-1:0]   SKIP_LAST = SKW'(LAT_M1);
  localparam logic [ADDRW-1:0] SIZE_A    = ADDRW'(SIZE);
  localparam logic [ADDRW-1:0] LAST_A    = ADDRW'(SIZE - 1);
  localparam logic [DATAW:0]   TOL_W     = (DATAW + 1)'(TOL);

  logic [1:0]       state_q, state_d;
  logic [SKW-1:0]   skip_cnt_q, skip_cnt_d;
  logic [ADDRW-1:0] idx_q, idx_d;
  logic             s1_v_q, s1_v_d;
  logic [ADDRW-1:0] s1_idx_q, s1_idx_d;
  logic [DATAW-1:0] s1_data_q, s1_data_d;
  logic [ADDRW-1:0] err_count_q, err_count_d;
  logic             first_flag_q, first_flag_d;
  logic [ADDRW-1:0] first_err_idx_q, first_err_idx_d;
  logic [DATAW-1:0] first_err_exp_q, first_err_exp_d;
  logic [DATAW-1:0] first_err_got_q, first_err_got_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      wi_count_q, wi_count_d;
  logic             stray_q, stray_d;

  logic [DATAW:0]   diff;
  logic [DATAW:0]   abs_diff;
  logic             mismatch;
  logic             last_cmp;

  // Sign-extend by one bit so the difference of any two words cannot overflow.
  assign diff     = {s1_data_q[DATAW-1], s1_data_q} - {gold_data[DATAW-1], gold_data};
  assign abs_diff = diff[DATAW] ? -diff : diff;
  assign mismatch = s1_v_q && (abs_diff > TOL_W);
  assign last_cmp = s1_v_q && (s1_idx_q == LAST_A);

  always_comb begin
    state_d         = state_q;
    skip_cnt_d      = skip_cnt_q;
    idx_d           = idx_q;
    s1_v_d          = 1'b0;
    s1_idx_d        = s1_idx_q;
    s1_data_d       = s1_data_q;
    err_count_d     = err_count_q;
    first_flag_d    = first_flag_q;
    first_err_idx_d = first_err_idx_q;
    first_err_exp_d = first_err_exp_q;
    first_err_got_d = first_err_got_q;
    done_d          = done_q;
    pass_d          = pass_q;
    wi_count_d      = wi_count_q;
    stray_d         = stray_q;

    if (mismatch) begin
      err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
      if (!first_flag_q) begin
        first_flag_d    = 1'b1;
        first_err_idx_d = s1_idx_q;
        first_err_exp_d = gold_data;
        first_err_got_d = s1_data_q;
      end
    end

    if (last_cmp) begin
      state_d    = S_DONE;
      done_d     = 1'b1;
      pass_d     = (err_count_d == '0);
      wi_count_d = wi_count_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ovalid_in) stray_d = 1'b1;
        if (start) begin
          state_d         = (IN_OUT_LAT == 0) ? S_CHECK : S_SKIP;
          skip_cnt_d      = '0;
          idx_d           = '0;
          err_count_d     = '0;
          first_flag_d    = 1'b0;
          first_err_idx_d = '0;
          first_err_exp_d = '0;
          first_err_got_d = '0;
          done_d          = 1'b0;
          pass_d          = 1'b0;
        end
      end
      S_SKIP: begin
        if (ovalid_in) begin
          skip_cnt_d = skip_cnt_q + 1'b1;
          if (skip_cnt_q == SKIP_LAST) state_d = S_CHECK;
        end
      end
      default: begin
        // Once every index has been issued, further beats are surplus.
        if (ovalid_in) begin
          if (idx_q < SIZE_A) begin
            s1_v_d    = 1'b1;
            s1_idx_d  = idx_q;
            s1_data_d = odata_in;
            idx_d     = idx_q + 1'b1;
          end else begin
            stray_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      skip_cnt_q      <= '0;
      idx_q           <= '0;
      s1_v_q          <= 1'b0;
      s1_idx_q        <= '0;
      s1_data_q       <= '0;
      err_count_q     <= '0;
      first_flag_q    <= 1'b0;
      first_err_idx_q <= '0;
      first_err_exp_q <= '0;
      first_err_got_q <= '0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      wi_count_q      <= '0;
      stray_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      skip_cnt_q      <= skip_cnt_d;
      idx_q           <= idx_d;
      s1_v_q          <= s1_v_d;
      s1_idx_q        <= s1_idx_d;
      s1_data_q       <= s1_data_d;
      err_count_q     <= err_count_d;
      first_flag_q    <= first_flag_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_exp_q <= first_err_exp_d;
      first_err_got_q <= first_err_got_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      wi_count_q      <= wi_count_d;
      stray_q         <= stray_d;
    end
  end

  assign gold_addr     = idx_q;
  assign res_we        = s1_v_q;
  assign res_addr      = s1_idx_q;
  assign res_data      = s1_data_q;
  assign busy          = (state_q == S_SKIP) || (state_q == S_CHECK);
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_got = first_err_got_q;
  assign wi_count      = wi_count_q;
  assign stray         = stray_q;

endmodule

// File: tb/tb_hdl_result_checker.sv
// Directed + randomized bench for hdl_result_checker against a list-level reference model.
module tb_hdl_result_checker;

  localparam int N      = 8;
  localparam int LAT    = 2;
  localparam int TB_TOL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ovalid_in = 1'b0;
  logic [31:0] odata_in = '0;
  logic [15:0] gold_addr;
  logic [31:0] gold_data = '0;
  logic        res_we;
  logic [15:0] res_addr;
  logic [31:0] res_data;
  logic        busy, done, pass, stray;
  logic [15:0] err_count, first_err_idx, wi_count;
  logic [31:0] first_err_exp, first_err_got;

  logic        start0 = 1'b0;
  logic        ovalid0 = 1'b0;
  logic [31:0] odata0 = '0;
  logic [15:0] gold_addr0;
  logic [31:0] gold_data0 = '0;
  logic        res_we0;
  logic [15:0] res_addr0;
  logic [31:0] res_data0;
  logic        busy0, done0, pass0, stray0;
  logic [15:0] err_count0, first_err_idx0, wi_count0;
  logic [31:0] first_err_exp0, first_err_got0;

  int          vectors = 0;
  int          miscompares = 0;
  int          wi_model = 0;
  logic [31:0] gold_mem [N];
  logic [31:0] got_arr [N];
  logic [47:0] wr_q [$];

  hdl_result_checker #(.DATAW(32), .SIZE(N), .IN_OUT_LAT(LAT), .ADDRW(16), .TOL(TB_TOL)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ovalid_in(ovalid_in), .odata_in(odata_in),
    .gold_addr(gold_addr), .gold_data(gold_data), .res_we(res_we), .res_addr(res_addr),
    .res_data(res_data), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .wi_count(wi_count), .stray(stray)
  );

  hdl_result_checker #(.DATAW(32), .SIZE(4), .IN_OUT_LAT(0), .ADDRW(16), .TOL(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ovalid_in(ovalid0), .odata_in(odata0),
    .gold_addr(gold_addr0), .gold_data(gold_data0), .res_we(res_we0), .res_addr(res_addr0),
    .res_data(res_data0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .first_err_idx(first_err_idx0), .first_err_exp(first_err_exp0), .first_err_got(first_err_got0),
    .wi_count(wi_count0), .stray(stray0)
  );

  always #5 clk = ~clk;

  // Synchronous-read golden RAMs
  always @(posedge clk) begin
    gold_data  <= (gold_addr < 16'(N)) ? gold_mem[gold_addr[2:0]] : 32'd0;
    gold_data0 <= 32'(gold_addr0) + 32'd10;
  end

  always @(negedge clk) begin
    if (rst_n && res_we) wr_q.push_back({res_addr, res_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [31:0] d);
    ovalid_in = 1'b1;
    odata_in  = d;
    @(posedge clk); #1;
    ovalid_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".err"}, err_count, 0);
    check({tag, ".fidx"}, first_err_idx, 0);
    check({tag, ".fexp"}, first_err_exp, 0);
    check({tag, ".fgot"}, first_err_got, 0);
    check({tag, ".wi"}, wi_count, 0);
    check({tag, ".we"}, res_we, 0);
    check({tag, ".gaddr"}, gold_addr, 0);
    check({tag, ".stray"}, stray, 0);
  endtask

  // One full work instance, checked against a model built from gold_mem/got_arr.
  task automatic run_inst(input string tag, input bit gaps, input bit mid_start);
    int          n_err;
    logic [15:0] f_idx;
    logic [31:0] f_exp, f_got;
    longint      d;
    wr_q.delete();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    for (int i = 0; i < LAT; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      beat($urandom);
    end
    for (int i = 0; i < N; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      if (mid_start && i == 4) begin
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        check({tag, ".busy_mid"}, busy, 1);
      end
      beat(got_arr[i]);
    end
    check({tag, ".done_early"}, done, 0);
    @(posedge clk); #1;

    n_err = 0; f_idx = '0; f_exp = '0; f_got = '0;
    for (int i = 0; i < N; i++) begin
      d = longint'($signed(got_arr[i])) - longint'($signed(gold_mem[i]));
      if (d < 0) d = -d;
      if (d > TB_TOL) begin
        if (n_err == 0) begin f_idx = 16'(i); f_exp = gold_mem[i]; f_got = got_arr[i]; end
        n_err++;
      end
    end
    wi_model++;

    check({tag, ".done"}, done, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".pass"}, pass, (n_err == 0));
    check({tag, ".err"}, err_count, n_err);
    check({tag, ".fidx"}, first_err_idx, f_idx);
    check({tag, ".fexp"}, first_err_exp, f_exp);
    check({tag, ".fgot"}, first_err_got, f_got);
    check({tag, ".wi"}, wi_count, wi_model);
    check({tag, ".nwr"}, wr_q.size(), N);
    for (int i = 0; i < N && i < wr_q.size(); i++)
      check({tag, ".wr"}, wr_q[i], {16'(i), got_arr[i]});
    idle(2);
  endtask

  initial begin
    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    idle(1);

    beat(32'h55);
    check("idle_beat.stray", stray, 1);
    check("idle_beat.busy", busy, 0);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    check("reset2.stray", stray, 0);

    for (int i = 0; i < N; i++) begin gold_mem[i] = 32'(i); got_arr[i] = 32'(i); end
    run_inst("clean", 1'b0, 1'b0);
    run_inst("stall", 1'b1, 1'b0);

    got_arr[3] = 32'd100;
    got_arr[6] = 32'd50;
    run_inst("mismatch", 1'b0, 1'b1);

    for (int i = 0; i < N; i++) gold_mem[i] = -32'sd5;
    got_arr[0] = -32'sd4; got_arr[1] = -32'sd5; got_arr[2] = -32'sd7; got_arr[3] = 32'sd5;
    got_arr[4] = -32'sd6; got_arr[5] = -32'sd3; got_arr[6] = -32'sd5; got_arr[7] = -32'sd4;
    run_inst("tol", 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        gold_mem[i] = (r == 3) ? 32'h7fff_fffe + 32'($urandom_range(0, 1)) : $urandom;
        got_arr[i]  = gold_mem[i] + 32'($urandom_range(0, 6)) - 32'd3;
      end
      run_inst("rand", 1'b1, 1'b0);
    end

    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    beat(32'd1); beat(32'd2); beat(32'd9); beat(32'd9);
    rst_n = 1'b0; @(posedge clk); #1;
    check_zero("midreset");
    rst_n = 1'b1;
    wi_model = 0;
    idle(1);
    for (int i = 0; i < N; i++) begin gold_mem[i] = 32'(i); got_arr[i] = 32'(i); end
    run_inst("restart1", 1'b0, 1'b0);
    run_inst("restart2", 1'b1, 1'b0);

    start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
    check("lat0.busy", busy0, 1);
    for (int i = 0; i < 4; i++) begin
      ovalid0 = 1'b1; odata0 = (i == 0) ? 32'd99 : 32'(i + 10);
      @(posedge clk); #1;
    end
    check("lat0.stray_pre", stray0, 0);
    odata0 = 32'd77;
    @(posedge clk); #1;
    ovalid0 = 1'b0;
    check("lat0.done", done0, 1);
    check("lat0.stray", stray0, 1);
    check("lat0.pass", pass0, 0);
    check("lat0.err", err_count0, 1);
    check("lat0.fidx", first_err_idx0, 0);
    check("lat0.fexp", first_err_exp0, 10);
    check("lat0.fgot", first_err_got0, 99);
    check("lat0.wi", wi_count0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
